// File: rtl/parity_rotator_pkg.sv
// Shared types and the reduction helper for the parity rotator.
// The helper reduces only the low w bits of a fixed-width vector, so one function serves every WIDTH.
package parity_rotator_pkg;

    typedef enum logic [1:0] {RED_XOR, RED_XNOR, RED_AND, RED_OR} red_mode_e;

    localparam int MAX_W = 64;

    // Only the low w bits take part, so zero-extension cannot disturb the AND result.
    function automatic logic reduce(input logic [MAX_W-1:0] vec, input int w,
                                    input red_mode_e mode);
        logic x, a, o;
        x = 1'b0;
        a = 1'b1;
        o = 1'b0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                x = x ^ vec[i];
                a = a & vec[i];
                o = o | vec[i];
            end
        end
        case (mode)
            RED_XOR:  return x;
            RED_XNOR: return ~x;
            RED_AND:  return a;
            default:  return o;
        endcase
    endfunction

endpackage

// File: rtl/parity_rotator_stepper.sv
// Rotating write-index register: advances by STEP modulo WIDTH and flags the wrap.
// The sum is one bit wider than the index, so index + STEP can never overflow.
module mod_stepper #(
    parameter int WIDTH = 4,
    parameter int STEP  = 1,
    localparam int IW   = $clog2(WIDTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          step,
    input  logic          clear,
    output logic [IW-1:0] index,
    output logic [IW-1:0] nxt_index,
    output logic          wrap
);

    logic [IW:0] sum;

    assign sum       = {1'b0, index} + (IW+1)'(STEP);
    assign wrap      = (sum >= (IW+1)'(WIDTH));
    assign nxt_index = wrap ? IW'(sum - (IW+1)'(WIDTH)) : IW'(sum);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   index <= '0;
        else if (clear) index <= '0;
        else if (step)  index <= nxt_index;
    end

endmodule

// File: rtl/parity_rotator.sv
// Rotating reduction-feedback register with a valid/ready frame output.
// Each step writes the selected reduction into the indexed bit; a wrap captures a frame.
module parity_rotator
    import parity_rotator_pkg::*;
#(
    parameter int             WIDTH    = 4,
    parameter int             STEP     = 1,
    parameter logic [WIDTH-1:0] INIT_VAL = '1,
    localparam int            IW       = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [IW-1:0]    index,
    output logic [WIDTH-1:0] state_q,
    output logic             red_out,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [WIDTH-1:0] frame_data
);

    logic             wrap;
    logic [IW-1:0]    nxt_idx;
    logic             stall, do_step, hs;
    logic [WIDTH-1:0] state_upd;

    assign red_out = reduce(MAX_W'(state_q), WIDTH, red_mode_e'(mode));

    // Only a wrapping step can stall; a dropped step is not remembered.
    assign stall   = wrap && frame_valid && !frame_ready;
    assign do_step = !load && enable && !stall;
    assign hs      = frame_valid && frame_ready;

    mod_stepper #(.WIDTH(WIDTH), .STEP(STEP)) u_stepper (
        .clock     (clock),
        .reset_n   (reset_n),
        .step      (do_step),
        .clear     (load),
        .index     (index),
        .nxt_index (nxt_idx),
        .wrap      (wrap)
    );

    always_comb begin
        state_upd = state_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (IW'(i) == index) state_upd[i] = red_out;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)     state_q <= INIT_VAL;
        else if (load)    state_q <= load_data;
        else if (do_step) state_q <= state_upd;
    end

    // Capture outranks the handshake clear, giving back-to-back frames.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_valid <= 1'b0;
            frame_data  <= '0;
        end else if (do_step && wrap) begin
            frame_valid <= 1'b1;
            frame_data  <= state_upd;
        end else if (hs) begin
            frame_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_parity_rotator.sv
// Directed bench for parity_rotator: a W=4/S=1 and a W=5/S=2 instance on one clock.
module tb_parity_rotator;

    logic       clock, reset_n;
    logic       en4, ld4, rdy4, red4, fv4;
    logic [1:0] mode4, idx4;
    logic [3:0] ldd4, st4, fd4;
    logic       en5, ld5, rdy5, red5, fv5;
    logic [1:0] mode5;
    logic [2:0] idx5;
    logic [4:0] ldd5, st5, fd5;

    int total = 0;
    int bad   = 0;

    parity_rotator #(.WIDTH(4), .STEP(1)) u4 (
        .clock(clock), .reset_n(reset_n), .enable(en4), .mode(mode4), .load(ld4),
        .load_data(ldd4), .index(idx4), .state_q(st4), .red_out(red4),
        .frame_valid(fv4), .frame_ready(rdy4), .frame_data(fd4)
    );

    parity_rotator #(.WIDTH(5), .STEP(2)) u5 (
        .clock(clock), .reset_n(reset_n), .enable(en5), .mode(mode5), .load(ld5),
        .load_data(ldd5), .index(idx5), .state_q(st5), .red_out(red5),
        .frame_valid(fv5), .frame_ready(rdy5), .frame_data(fd5)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [2:0] exp_idx5 [5];
        logic       exp_cap5 [5];
        logic [3:0] exp_st3  [3];
        exp_idx5 = '{3'd2, 3'd4, 3'd1, 3'd3, 3'd0};
        exp_cap5 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_st3  = '{4'b1111, 4'b1101, 4'b1101};

        reset_n = 1'b0;
        en4 = 0; ld4 = 0; ldd4 = '0; rdy4 = 1; mode4 = 2'd0;
        en5 = 0; ld5 = 0; ldd5 = '0; rdy5 = 1; mode5 = 2'd0;
        #12;
        chk("rst_idx",   32'(idx4), 32'd0);
        chk("rst_state", 32'(st4),  32'hF);
        chk("rst_fv",    32'(fv4),  32'd0);
        chk("rst_fd",    32'(fd4),  32'd0);
        chk("rst_red",   32'(red4), 32'd0);
        chk("rst_state5",32'(st5),  32'h1F);
        reset_n = 1'b1;

        // W=4 S=1 XOR, enable held, ready high
        en4 = 1;
        for (int s = 1; s <= 4; s++) begin
            tick();
            chk("t1_idx",   32'(idx4), 32'(s % 4));
            chk("t1_state", 32'(st4),  32'b1110);
            chk("t1_fv",    32'(fv4),  32'(s == 4));
        end
        chk("t1_fd", 32'(fd4), 32'b1110);
        tick();
        chk("t1_hs_fv",  32'(fv4),  32'd0);
        chk("t1_hs_idx", 32'(idx4), 32'd1);
        en4 = 0;

        // W=5 S=2: captures only on the wrapping steps
        en5 = 1;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("t2_idx", 32'(idx5), 32'(exp_idx5[s]));
            chk("t2_fv",  32'(fv5),  32'(exp_cap5[s]));
            if (s == 2) chk("t2_fd", 32'(fd5), 32'h1F);
        end
        en5 = 0;

        // Back-pressure: stall at the wrap, then deliver and recapture in one cycle
        pulse_reset();
        rdy4 = 0; en4 = 1; mode4 = 2'd0;
        for (int s = 0; s < 4; s++) tick();
        chk("t3_fv1",  32'(fv4),  32'd1);
        chk("t3_fd1",  32'(fd4),  32'b1110);
        chk("t3_idx0", 32'(idx4), 32'd0);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("t3_state", 32'(st4),  32'(exp_st3[s]));
            chk("t3_idx",   32'(idx4), 32'(s + 1));
        end
        tick();
        tick();
        chk("t3_stall_idx",   32'(idx4), 32'd3);
        chk("t3_stall_state", 32'(st4),  32'b1101);
        chk("t3_stall_fd",    32'(fd4),  32'b1110);
        chk("t3_stall_fv",    32'(fv4),  32'd1);
        rdy4 = 1;
        tick();
        rdy4 = 0;
        chk("t3_b2b_fv",  32'(fv4),  32'd1);
        chk("t3_b2b_fd",  32'(fd4),  32'b1101);
        chk("t3_b2b_idx", 32'(idx4), 32'd0);

        // Load at index 2 with a frame pending
        tick();
        tick();
        chk("t4_pre_idx",   32'(idx4), 32'd2);
        chk("t4_pre_state", 32'(st4),  32'b1111);
        ld4 = 1; ldd4 = 4'b0101;
        tick();
        chk("t4_state", 32'(st4),  32'b0101);
        chk("t4_idx",   32'(idx4), 32'd0);
        chk("t4_fv",    32'(fv4),  32'd1);
        chk("t4_fd",    32'(fd4),  32'b1101);
        rdy4 = 1;
        tick();
        chk("t4_ld_hs_fv", 32'(fv4), 32'd0);
        ld4 = 0; rdy4 = 0; en4 = 0;

        // AND holds all-ones; mode changes reach red_out with no clock
        mode4 = 2'd2;
        pulse_reset();
        #1;
        chk("t5_and_red", 32'(red4), 32'd1);
        en4 = 1;
        tick();
        en4 = 0;
        chk("t5_and_state", 32'(st4),  32'hF);
        chk("t5_and_idx",   32'(idx4), 32'd1);
        ld4 = 1; ldd4 = 4'b0000;
        tick();
        ld4 = 0;
        chk("t5_ld_state", 32'(st4), 32'd0);
        mode4 = 2'd1;
        #1;
        chk("t5_xnor_red", 32'(red4), 32'd1);
        mode4 = 2'd3;
        #1;
        chk("t5_or_red", 32'(red4), 32'd0);

        // Async reset mid-cycle with a pending frame at index 2
        mode4 = 2'd0;
        pulse_reset();
        rdy4 = 0; en4 = 1;
        for (int s = 0; s < 6; s++) tick();
        en4 = 0;
        chk("t6_pre_fv",  32'(fv4),  32'd1);
        chk("t6_pre_idx", 32'(idx4), 32'd2);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6_idx",   32'(idx4), 32'd0);
        chk("t6_state", 32'(st4),  32'hF);
        chk("t6_fv",    32'(fv4),  32'd0);
        chk("t6_fd",    32'(fd4),  32'd0);
        #1;
        reset_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
